bias_relu_serializer: RTL and testbench
=======================================

# bias_relu_serializer

Output stage of a layer's adder-tree datapath. Accepts one vector of N_adder_tree signed partial sums, adds the per-channel constant bias vector from the layer's BIAS bank, and applies saturating ReLU. It then streams the results one channel per cycle, with a valid/ready handshake, into the next layer's feature-map buffer. It sits directly downstream of the adder trees and the layer BIAS bank.

## Interface
- N_adder_tree, 16, number of parallel channels per vector (power of 2, ≥2)
- DW, 18, signed two's-complement data width of sums, biases and outputs
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  sum vector present on `sums`
- in_ready  output  1  stage can capture a vector this cycle
- sums  input  N_adder_tree*DW  channel i at bits [DW*(i+1)-1:DW*i], signed
- bias  input  N_adder_tree*DW  constant per-channel bias, same packing as `sums`, signed
- out_valid  output  1  `out_data` holds a result
- out_ready  input  1  downstream accepts `out_data` this cycle
- out_data  output  DW  biased, saturated, ReLU'd channel value (always ≥0)
- out_ch  output  $clog2(N_adder_tree)  channel index of `out_data`
- out_last  output  1  high with the final channel (N_adder_tree-1) of a vector

## Operation
- Per lane i, evaluated combinationally at capture:
  - t = sext(sums_i) + sext(bias_i), computed DW+1 bits wide.
  - If t > 2^(DW-1)-1, the result is 2^(DW-1)-1 (131071 for DW=18).
  - If t < 0, the result is 0.
  - Otherwise the result is t[DW-1:0].
- Lane results are stored in an N_adder_tree-entry register bank on capture. The bias is sampled only at capture.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid, capture the bank, clear ch_cnt to 0, go to SEND.
  - SEND: out_valid=1, out_data=bank[ch_cnt], out_ch=ch_cnt, out_last=(ch_cnt==N_adder_tree-1).
    - On out_valid&&out_ready with ch_cnt<N-1: increment ch_cnt.
    - On the transfer of the last channel:
      - If in_valid is also high, capture the new vector and stay in SEND with ch_cnt=0. This is back-to-back operation with no bubble.
      - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==SEND && out_last && out_ready). This is a combinational function of state and out_ready.
- Backpressure: while out_valid && !out_ready, out_data, out_ch and out_last hold stable, and the bank is not overwritten.
- in_valid is ignored whenever in_ready=0. Upstream must hold `sums` until the handshake completes.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, ch_cnt=0, bank cleared to 0.
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after release.
- Latency:
  - A vector captured at edge k presents channel 0 with out_valid=1 in cycle k+1.
  - With out_ready held high, channel j appears in cycle k+1+j.
  - out_last appears in cycle k+N_adder_tree.
- Throughput: one vector per N_adder_tree cycles with continuous out_ready.
- Reset mid-vector: all remaining channels are discarded, and the outputs return to their reset values immediately.
- All outputs except in_ready are registered or decoded from registered state. There is no combinational path from in_valid to any output.

## Structure
- Shared package (layer-wide):
  - DW.
  - SAT_MAX = 2^(DW-1)-1.
  - The FSM state enum {IDLE, SEND}.
  - Channel-index width function.
- One sub-module, `bias_relu_lane`: combinational per-lane sign-extend, add, saturate and ReLU. It is instantiated N_adder_tree times with a generate loop.
- The top level holds the register bank, ch_cnt and the FSM.

## Test plan
- Reset release, then capture sums_0=20000, bias_0=-13640, other lanes sum=0/bias=0 → cycle k+1: out_ch=0, out_data=6360, out_valid=1; channels 1..15 read 0; out_last only on ch 15.
- Lane 3: sum=131000, bias=8352 → out_data=131071 (positive saturation). Lane 5: sum=-131072, bias=-20 → out_data=0 (negative overflow clipped by ReLU).
- Lane 7: sum=5, bias=-6 → 0. Lane 8: sum=-6, bias=6 → 0. Lane 9: sum=100, bias=-100 → 0.
- out_ready toggled 1,0,0,1 during ch 2–4 → out_data and out_ch stable across stall cycles, no channel skipped or repeated, exactly 16 transfers.
- Two vectors with in_valid held high → second captured on the edge of the first's out_last transfer; its ch 0 follows immediately; in_ready pulses exactly once per vector.
- Assert rst at ch 6 of a vector → out_valid=0 and out_data=0 asynchronously; after release in_ready=1 and a new vector starts at ch 0.

Source files
------------

// File: rtl/bias_relu_serializer_pkg.sv
// Layer-wide definitions shared by the bias/ReLU output stage.
// Holds data width, saturation limit, FSM state encoding and channel-index sizing.
package bias_relu_serializer_pkg;

   localparam int DW = 18;
   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bias_relu_lane.sv
// One channel of the output stage: sign-extend, add bias, saturate high, clip negatives.
module bias_relu_lane
   import bias_relu_serializer_pkg::*;
(
   input  logic [DW-1:0] sum_i,
   input  logic [DW-1:0] bias_i,
   output logic [DW-1:0] res_o
);

   logic [DW:0] t;

   // One extra bit keeps the true sum: MSB flags negative, next bit flags overflow.
   always_comb begin
      t = {sum_i[DW-1], sum_i} + {bias_i[DW-1], bias_i};
      if (t[DW]) begin
         res_o = '0;
      end else if (t[DW-1]) begin
         res_o = SAT_MAX;
      end else begin
         res_o = t[DW-1:0];
      end
   end

endmodule

// File: rtl/bias_relu_serializer.sv
// Captures a biased/ReLU'd sum vector into a bank and streams it one channel per cycle.
// state | meaning: IDLE = bank empty, accepting a vector; SEND = presenting bank[ch_cnt].
module bias_relu_serializer
   import bias_relu_serializer_pkg::*;
#(
   parameter int N_adder_tree = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [N_adder_tree*DW-1:0]        sums,
   input  logic [N_adder_tree*DW-1:0]        bias,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DW-1:0]                     out_data,
   output logic [ch_width(N_adder_tree)-1:0] out_ch,
   output logic                              out_last
);

   localparam int CW = ch_width(N_adder_tree);
   localparam logic [CW-1:0] LAST_CH = CW'(N_adder_tree - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] ch_cnt_q, ch_cnt_d;
   logic [DW-1:0] bank_q [N_adder_tree];
   logic [DW-1:0] lane_res [N_adder_tree];
   logic          capture;
   logic          at_last;

   for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      bias_relu_lane u_lane (
         .sum_i  (sums[DW*i +: DW]),
         .bias_i (bias[DW*i +: DW]),
         .res_o  (lane_res[i])
      );
   end

   assign at_last   = (state_q == SEND) && (ch_cnt_q == LAST_CH);
   assign out_valid = (state_q == SEND);
   assign out_data  = bank_q[ch_cnt_q];
   assign out_ch    = ch_cnt_q;
   assign out_last  = at_last;
   // Gated by rst so upstream never sees a handshake while the stage is held in reset.
   assign in_ready  = !rst && ((state_q == IDLE) || (at_last && out_ready));

   always_comb begin
      state_d  = state_q;
      ch_cnt_d = ch_cnt_q;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               capture  = 1'b1;
               ch_cnt_d = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (ch_cnt_q == LAST_CH) begin
                  ch_cnt_d = '0;
                  if (in_valid) begin
                     capture = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  ch_cnt_d = ch_cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d  = IDLE;
            ch_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ch_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ch_cnt_q <= ch_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= '{default: '0};
      end else if (capture) begin
         bank_q <= lane_res;
      end
   end

endmodule

// File: tb/tb_bias_relu_serializer.sv
// Directed bench for bias_relu_serializer: saturation/ReLU corners, stalls, back-to-back, mid-vector reset.
module tb_bias_relu_serializer;

   localparam int N  = 16;
   localparam int DW = 18;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] sums;
   logic [N*DW-1:0] bias;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [3:0]      out_ch;
   logic            out_last;

   int n_chk  = 0;
   int n_fail = 0;

   logic signed [DW-1:0] vs_sum  [3][N];
   logic signed [DW-1:0] vs_bias [3][N];
   logic        [DW-1:0] vs_exp  [3][N];

   bias_relu_serializer #(.N_adder_tree(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sums      (sums),
      .bias      (bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic present(input int v);
      for (int i = 0; i < N; i++) begin
         sums[DW*i +: DW] = vs_sum[v][i];
         bias[DW*i +: DW] = vs_bias[v][i];
      end
   endtask

   // Presents vectors first..first+n_vec-1 with in_valid held high and checks every output cycle.
   task automatic stream(input int first, input int n_vec, input bit stall);
      int  idx, done_vec, captured, pulses, cyc, cur;
      bit  cap, xfer, prev_stall;
      logic [DW-1:0] prev_data;
      idx = 0; done_vec = 0; captured = 0; pulses = 0; cyc = 0;
      cap = 1'b0; prev_stall = 1'b0; prev_data = '0;
      @(negedge clk);
      present(first);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk_eq("idle_in_ready", in_ready, 1);
      captured = 1; pulses = 1;
      while (done_vec < n_vec && cyc < 200) begin
         @(negedge clk);
         if (captured < n_vec) present(first + captured);
         else in_valid = 1'b0;
         out_ready = stall ? !(cyc == 3 || cyc == 4) : 1'b1;
         #1;
         cur = first + done_vec;
         chk_eq("out_valid", out_valid, 1);
         chk_eq("out_ch", out_ch, idx);
         chk_eq("out_data", out_data, vs_exp[cur][idx]);
         chk_eq("out_last", out_last, idx == N - 1);
         chk_eq("in_ready", in_ready, (idx == N - 1) && out_ready);
         if (prev_stall) chk_eq("stall_hold", out_data, prev_data);
         xfer = out_valid && out_ready;
         cap  = in_ready && in_valid;
         if (cap) begin
            captured++;
            pulses++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         if (xfer) begin
            if (idx == N - 1) begin
               idx = 0;
               done_vec++;
            end else begin
               idx++;
            end
         end
         cyc++;
      end
      chk_eq("stream_done", done_vec, n_vec);
      chk_eq("in_ready_pulses", pulses, n_vec);
      chk_eq("cycles", cyc, n_vec * N + (stall ? 2 : 0));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_eq("drained_valid", out_valid, 0);
      chk_eq("drained_in_ready", in_ready, 1);
   endtask

   initial begin
      for (int v = 0; v < 3; v++)
         for (int i = 0; i < N; i++) begin
            vs_sum[v][i] = '0; vs_bias[v][i] = '0; vs_exp[v][i] = '0;
         end
      vs_sum[0][0] = 20000;   vs_bias[0][0] = -13640; vs_exp[0][0] = 6360;
      vs_sum[0][1] = 500;     vs_bias[0][1] = 1000;   vs_exp[0][1] = 1500;
      vs_sum[0][3] = 131000;  vs_bias[0][3] = 8352;   vs_exp[0][3] = 131071;
      vs_sum[0][5] = -131072; vs_bias[0][5] = -20;    vs_exp[0][5] = 0;
      vs_sum[0][7] = 5;       vs_bias[0][7] = -6;     vs_exp[0][7] = 0;
      vs_sum[0][8] = -6;      vs_bias[0][8] = 6;      vs_exp[0][8] = 0;
      vs_sum[0][9] = 100;     vs_bias[0][9] = -100;   vs_exp[0][9] = 0;
      vs_sum[0][15] = 7;      vs_bias[0][15] = 0;     vs_exp[0][15] = 7;
      for (int i = 0; i < N; i++) begin
         vs_sum[1][i]  = DW'(i * 1000);
         vs_bias[1][i] = -2000;
         vs_exp[1][i]  = (i < 2) ? '0 : DW'((i - 2) * 1000);
         vs_sum[2][i]  = DW'(-50 * i);
         vs_bias[2][i] = 1000;
         vs_exp[2][i]  = DW'(1000 - 50 * i);
      end

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sums = '0; bias = '0;
      repeat (2) @(negedge clk);
      #1;
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_out_valid", out_valid, 0);
      chk_eq("rst_out_data", out_data, 0);
      chk_eq("rst_out_ch", out_ch, 0);
      chk_eq("rst_out_last", out_last, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("release_in_ready", in_ready, 1);

      stream(0, 1, 1'b0);
      stream(0, 1, 1'b1);
      stream(1, 2, 1'b0);

      // Reset while channel 6 of a vector is on the output.
      @(negedge clk);
      present(1);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      chk_eq("pre_rst_ch", out_ch, 6);
      chk_eq("pre_rst_data", out_data, vs_exp[1][6]);
      rst = 1'b1;
      #1;
      chk_eq("midrst_valid", out_valid, 0);
      chk_eq("midrst_data", out_data, 0);
      chk_eq("midrst_ch", out_ch, 0);
      chk_eq("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("post_rst_in_ready", in_ready, 1);
      chk_eq("post_rst_valid", out_valid, 0);
      stream(2, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
